// File: rtl/fifo_wr_sched_pkg.sv
// Shared encodings for the FIFO write-side scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_wr_sched_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SEND_REG    = 2'd1,
        SEND_ALU_LO = 2'd2,
        SEND_ALU_HI = 2'd3
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_REG  = 2'b01;
    localparam logic [1:0] GNT_ALU  = 2'b10;

    // Encoding of the remembered previous winner.
    localparam logic LAST_REG = 1'b0;
    localparam logic LAST_ALU = 1'b1;

endpackage

// File: rtl/fifo_wr_sched_rr_arb2.sv
// Two-requester round-robin arbiter; bit0 = REG, bit1 = ALU.
// Latency: purely combinational, no state held here.
// Backpressure: en low suppresses every grant.
module rr_arb2
    import fifo_wr_sched_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       en,
    output logic [1:0] gnt
);

    // A single requester wins outright; on a tie the one that did not win last time goes.
    always_comb begin
        gnt = GNT_NONE;
        if (en) begin
            case (req)
                2'b01:   gnt = GNT_REG;
                2'b10:   gnt = GNT_ALU;
                2'b11:   gnt = (last_grant == LAST_ALU) ? GNT_REG : GNT_ALU;
                default: gnt = GNT_NONE;
            endcase
        end
    end

endmodule

// File: rtl/fifo_wr_sched.sv
// Shares the async FIFO write port between REG readback (1 byte) and ALU results (2 bytes, low first).
// Latency: accept in cycle N, first beat written in N+1, ALU high beat in N+2.
// Backpressure: wfull stalls the current beat with winc low and wr_data held; no new accept until done.
module fifo_wr_sched
    import fifo_wr_sched_pkg::*;
#(
    parameter int DW    = 8,
    parameter int CNT_W = 16
) (
    input  logic              wclk,
    input  logic              wrst_n,
    input  logic              reg_valid,
    input  logic [DW-1:0]     reg_data,
    output logic              reg_ready,
    input  logic              alu_valid,
    input  logic [2*DW-1:0]   alu_data,
    output logic              alu_ready,
    input  logic              wfull,
    output logic              winc,
    output logic [DW-1:0]     wr_data,
    output logic              busy,
    output logic [1:0]        grant,
    output logic [CNT_W-1:0]  push_cnt
);

    state_t            state;
    state_t            state_nxt;
    logic [2*DW-1:0]   hold;
    logic              last_grant;
    logic [1:0]        arb_gnt;
    logic              accept_reg;
    logic              accept_alu;

    // Arbitration only runs in IDLE and is forced off while reset is asserted.
    rr_arb2 u_arb (
        .req        ({alu_valid, reg_valid}),
        .last_grant (last_grant),
        .en         (wrst_n && (state == IDLE)),
        .gnt        (arb_gnt)
    );

    assign reg_ready  = arb_gnt[0];
    assign alu_ready  = arb_gnt[1];
    assign accept_reg = reg_valid && reg_ready;
    assign accept_alu = alu_valid && alu_ready;
    assign busy       = wrst_n && (state != IDLE);

    // Next state plus the write-port outputs; a beat retires only when wfull is low.
    always_comb begin
        state_nxt = state;
        winc      = 1'b0;
        wr_data   = '0;
        grant     = GNT_NONE;
        case (state)
            IDLE: begin
                grant = arb_gnt;
                if (accept_reg)      state_nxt = SEND_REG;
                else if (accept_alu) state_nxt = SEND_ALU_LO;
            end
            SEND_REG: begin
                grant   = GNT_REG;
                wr_data = hold[DW-1:0];
                winc    = !wfull;
                if (!wfull) state_nxt = IDLE;
            end
            SEND_ALU_LO: begin
                grant   = GNT_ALU;
                wr_data = hold[DW-1:0];
                winc    = !wfull;
                if (!wfull) state_nxt = SEND_ALU_HI;
            end
            SEND_ALU_HI: begin
                grant   = GNT_ALU;
                wr_data = hold[2*DW-1:DW];
                winc    = !wfull;
                if (!wfull) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Reset must kill the write strobe immediately, not at the next edge.
        if (!wrst_n) begin
            winc    = 1'b0;
            wr_data = '0;
            grant   = GNT_NONE;
        end
    end

    // State register, holding register and round-robin history.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state      <= IDLE;
            hold       <= '0;
            last_grant <= LAST_ALU;
        end else begin
            state <= state_nxt;
            if (accept_reg) begin
                hold       <= {{DW{1'b0}}, reg_data};
                last_grant <= LAST_REG;
            end else if (accept_alu) begin
                hold       <= alu_data;
                last_grant <= LAST_ALU;
            end
        end
    end

    // Count every byte actually pushed into the FIFO; wraps naturally.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            push_cnt <= '0;
        end else if (winc) begin
            push_cnt <= push_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_fifo_wr_sched.sv
module tb_fifo_wr_sched;

    localparam int DW    = 8;
    localparam int CNT_W = 4;

    logic              wclk = 1'b0;
    logic              wrst_n;
    logic              reg_valid;
    logic [DW-1:0]     reg_data;
    logic              reg_ready;
    logic              alu_valid;
    logic [2*DW-1:0]   alu_data;
    logic              alu_ready;
    logic              wfull;
    logic              winc;
    logic [DW-1:0]     wr_data;
    logic              busy;
    logic [1:0]        grant;
    logic [CNT_W-1:0]  push_cnt;

    logic [DW-1:0] exp_q[$];
    int checks   = 0;
    int errors   = 0;
    int winc_cnt = 0;

    fifo_wr_sched #(.DW(DW), .CNT_W(CNT_W)) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .reg_valid (reg_valid),
        .reg_data  (reg_data),
        .reg_ready (reg_ready),
        .alu_valid (alu_valid),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wr_data   (wr_data),
        .busy      (busy),
        .grant     (grant),
        .push_cnt  (push_cnt)
    );

    always #5 wclk = ~wclk;

    // Scoreboard: every FIFO write must match the next expected byte.
    always @(negedge wclk) begin
        if (wrst_n === 1'b1 && winc === 1'b1) begin
            logic [DW-1:0] exp;
            winc_cnt = winc_cnt + 1;
            checks   = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL wr_data unexpected write got %02h want none", wr_data);
            end else begin
                exp = exp_q.pop_front();
                if (wr_data !== exp) begin
                    errors = errors + 1;
                    $display("FAIL wr_data got %02h want %02h", wr_data, exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        wrst_n    = 1'b0;
        reg_valid = 1'b0;
        reg_data  = '0;
        alu_valid = 1'b0;
        alu_data  = '0;
        wfull     = 1'b0;
        repeat (2) @(posedge wclk);
        #3;
        wrst_n = 1'b1;
        exp_q.delete();
        winc_cnt = 0;
        tick();
    endtask

    task automatic check_empty(input string name);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL %s leftover bytes got %0d want 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        wrst_n    = 1'b0;
        reg_valid = 1'b1;
        reg_data  = 8'h11;
        alu_valid = 1'b1;
        alu_data  = 16'h2233;
        wfull     = 1'b0;
        @(posedge wclk);
        #2;
        checks = checks + 1;
        if ({reg_ready, alu_ready, winc, busy, grant} !== 6'b0) begin
            errors = errors + 1;
            $display("FAIL reset_ctrl got %b want 000000", {reg_ready, alu_ready, winc, busy, grant});
        end
        checks = checks + 1;
        if (wr_data !== 8'h00 || push_cnt !== 4'h0) begin
            errors = errors + 1;
            $display("FAIL reset_data got wr_data=%02h push_cnt=%0d want 00/0", wr_data, push_cnt);
        end
    endtask

    task automatic test_reg_only();
        do_reset();
        reg_valid = 1'b1;
        reg_data  = 8'hA5;
        exp_q.push_back(8'hA5);
        @(negedge wclk);
        checks = checks + 1;
        if (reg_ready !== 1'b1 || alu_ready !== 1'b0 || winc !== 1'b0 || grant !== 2'b01) begin
            errors = errors + 1;
            $display("FAIL reg_accept got rdy=%b winc=%b grant=%b want 1/0/01", reg_ready, winc, grant);
        end
        tick();
        reg_valid = 1'b0;
        reg_data  = '0;
        @(negedge wclk);
        checks = checks + 1;
        if (winc !== 1'b1 || busy !== 1'b1 || grant !== 2'b01 || push_cnt !== 4'd0) begin
            errors = errors + 1;
            $display("FAIL reg_send got winc=%b busy=%b grant=%b cnt=%0d want 1/1/01/0", winc, busy, grant, push_cnt);
        end
        tick();
        @(negedge wclk);
        checks = checks + 1;
        if (busy !== 1'b0 || winc !== 1'b0 || push_cnt !== 4'd1) begin
            errors = errors + 1;
            $display("FAIL reg_done got busy=%b winc=%b cnt=%0d want 0/0/1", busy, winc, push_cnt);
        end
        check_empty("reg_only");
    endtask

    task automatic test_alu_only();
        do_reset();
        alu_valid = 1'b1;
        alu_data  = 16'h1234;
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h12);
        @(negedge wclk);
        checks = checks + 1;
        if (alu_ready !== 1'b1 || reg_ready !== 1'b0 || grant !== 2'b10) begin
            errors = errors + 1;
            $display("FAIL alu_accept got rdy=%b grant=%b want 1/10", alu_ready, grant);
        end
        tick();
        alu_valid = 1'b0;
        alu_data  = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge wclk);
            checks = checks + 1;
            if (winc !== 1'b1 || grant !== 2'b10) begin
                errors = errors + 1;
                $display("FAIL alu_beat%0d got winc=%b grant=%b want 1/10", i, winc, grant);
            end
            tick();
        end
        @(negedge wclk);
        checks = checks + 1;
        if (busy !== 1'b0 || push_cnt !== 4'd2) begin
            errors = errors + 1;
            $display("FAIL alu_done got busy=%b cnt=%0d want 0/2", busy, push_cnt);
        end
        check_empty("alu_only");
    endtask

    task automatic test_tie();
        do_reset();
        reg_valid = 1'b1;
        reg_data  = 8'h5A;
        alu_valid = 1'b1;
        alu_data  = 16'hABCD;
        @(negedge wclk);
        checks = checks + 1;
        if (reg_ready !== 1'b1 || alu_ready !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL tie1 got reg_rdy=%b alu_rdy=%b want 1/0", reg_ready, alu_ready);
        end
        exp_q.push_back(8'h5A);
        tick();
        reg_data = 8'h77;
        tick();
        @(negedge wclk);
        checks = checks + 1;
        if (alu_ready !== 1'b1 || reg_ready !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL tie2 got reg_rdy=%b alu_rdy=%b want 0/1", reg_ready, alu_ready);
        end
        exp_q.push_back(8'hCD);
        exp_q.push_back(8'hAB);
        tick();
        alu_data = 16'h4321;
        repeat (2) tick();
        @(negedge wclk);
        checks = checks + 1;
        if (reg_ready !== 1'b1 || alu_ready !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL tie3 got reg_rdy=%b alu_rdy=%b want 1/0", reg_ready, alu_ready);
        end
        exp_q.push_back(8'h77);
        tick();
        reg_valid = 1'b0;
        alu_valid = 1'b0;
        tick();
        @(negedge wclk);
        checks = checks + 1;
        if (push_cnt !== 4'd4) begin
            errors = errors + 1;
            $display("FAIL tie_cnt got %0d want 4", push_cnt);
        end
        check_empty("tie");
    endtask

    task automatic test_full_stall();
        do_reset();
        alu_valid = 1'b1;
        alu_data  = 16'hABCD;
        exp_q.push_back(8'hCD);
        exp_q.push_back(8'hAB);
        tick();
        alu_valid = 1'b0;
        alu_data  = '0;
        tick();
        wfull = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge wclk);
            checks = checks + 1;
            if (winc !== 1'b0 || wr_data !== 8'hAB || busy !== 1'b1) begin
                errors = errors + 1;
                $display("FAIL stall%0d got winc=%b wr_data=%02h busy=%b want 0/ab/1", i, winc, wr_data, busy);
            end
            tick();
        end
        wfull = 1'b0;
        @(negedge wclk);
        checks = checks + 1;
        if (winc !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL stall_release got winc=%b want 1", winc);
        end
        repeat (2) tick();
        @(negedge wclk);
        checks = checks + 1;
        if (winc_cnt != 2 || push_cnt !== 4'd2) begin
            errors = errors + 1;
            $display("FAIL stall_pulses got %0d cnt=%0d want 2/2", winc_cnt, push_cnt);
        end
        check_empty("stall");
    endtask

    task automatic test_valid_drop();
        do_reset();
        alu_valid = 1'b1;
        alu_data  = 16'h9988;
        exp_q.push_back(8'h88);
        exp_q.push_back(8'h99);
        tick();
        alu_valid = 1'b0;
        reg_valid = 1'b1;
        reg_data  = 8'hEE;
        tick();
        reg_valid = 1'b0;
        reg_data  = '0;
        repeat (3) tick();
        @(negedge wclk);
        checks = checks + 1;
        if (push_cnt !== 4'd2 || busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL valid_drop got cnt=%0d busy=%b want 2/0", push_cnt, busy);
        end
        check_empty("valid_drop");
    endtask

    task automatic test_reset_mid();
        do_reset();
        alu_valid = 1'b1;
        alu_data  = 16'h1234;
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h12);
        tick();
        alu_valid = 1'b0;
        tick();
        checks = checks + 1;
        if (winc !== 1'b1 || grant !== 2'b10 || wr_data !== 8'h12) begin
            errors = errors + 1;
            $display("FAIL mid_hi got winc=%b grant=%b wr_data=%02h want 1/10/12", winc, grant, wr_data);
        end
        wrst_n = 1'b0;
        #1;
        checks = checks + 1;
        if (winc !== 1'b0 || grant !== 2'b00 || busy !== 1'b0 || push_cnt !== 4'd0) begin
            errors = errors + 1;
            $display("FAIL mid_reset got winc=%b grant=%b busy=%b cnt=%0d want 0/00/0/0", winc, grant, busy, push_cnt);
        end
        exp_q.delete();
        @(posedge wclk);
        #3;
        wrst_n = 1'b1;
        tick();
        reg_valid = 1'b1;
        reg_data  = 8'h3C;
        exp_q.push_back(8'h3C);
        tick();
        reg_valid = 1'b0;
        repeat (2) tick();
        @(negedge wclk);
        checks = checks + 1;
        if (push_cnt !== 4'd1 || busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL after_reset got cnt=%0d busy=%b want 1/0", push_cnt, busy);
        end
        check_empty("reset_mid");
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            logic [CNT_W-1:0] want;
            want      = CNT_W'(i % 16);
            reg_valid = 1'b1;
            reg_data  = 8'(i);
            exp_q.push_back(8'(i));
            tick();
            reg_valid = 1'b0;
            tick();
            checks = checks + 1;
            if (push_cnt !== want) begin
                errors = errors + 1;
                $display("FAIL wrap push %0d got %0d want %0d", i, push_cnt, want);
            end
        end
        check_empty("wrap");
    endtask

    initial begin
        test_reset();
        test_reg_only();
        test_alu_only();
        test_tie();
        test_full_stall();
        test_valid_drop();
        test_reset_mid();
        test_wrap();
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
